// File: rtl/iob_rom_sp_reader.sv
// Block reader for a one-cycle-latency single-port ROM, delivering words on a valid/ready stream.
// Optional multi-pass looping is enabled with `define IOB_ROM_SP_READER_LOOP_EN (adds input loop).
module iob_rom_sp_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
`ifdef IOB_ROM_SP_READER_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    // Stream handshake: a word transfers on any rising edge where m_valid and m_ready are both 1;
    // once m_valid rises, m_valid and m_data hold until that transfer happens.
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   deliver_cnt;
    logic              rd_pend;
    logic [1:0]        occ;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] data_buf [2];
    logic [1:0]        last_buf;

    logic              pop;
    logic              loop_now;
    logic              final_pop;
    logic [2:0]        proj;

`ifdef IOB_ROM_SP_READER_LOOP_EN
    assign loop_now = loop;
`else
    assign loop_now = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign m_valid   = (occ != 2'd0);
    assign m_data    = data_buf[rd_ptr];
    assign m_last    = last_buf[rd_ptr] & m_valid;
    assign pop       = m_valid & m_ready;

    // Occupancy after this cycle's in-flight write and pop; a new read only fits below 2.
    assign proj      = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    assign rom_r_en  = (state == RUN) && (issue_cnt != '0) && (proj < 3'd2);
    assign rom_addr  = rom_r_en ? addr_cnt : last_addr;

    // In loop mode an earlier pass's last word may still be queued, so only the sole remaining word ends it.
    assign final_pop = (state == FLUSH) && pop && m_last && (occ == 2'd1) && !rd_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            addr_cnt    <= '0;
            last_addr   <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            rd_pend     <= 1'b0;
            occ         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            last_buf    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            rd_pend <= rom_r_en;

            if (rom_r_en) begin
                last_addr <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
                issue_cnt <= issue_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state       <= RUN;
                            addr_cnt    <= base_addr;
                            base_q      <= base_addr;
                            len_q       <= len;
                            issue_cnt   <= len;
                            deliver_cnt <= len;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rom_r_en && (issue_cnt == (ADDR_W+1)'(1))) begin
                        if (loop_now) begin
                            addr_cnt  <= base_q;
                            issue_cnt <= len_q;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (final_pop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rd_pend) begin
                data_buf[wr_ptr] <= rom_r_data;
                last_buf[wr_ptr] <= (deliver_cnt == (ADDR_W+1)'(1));
                wr_ptr           <= ~wr_ptr;
                deliver_cnt      <= (deliver_cnt == (ADDR_W+1)'(1)) ? len_q : deliver_cnt - 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

endmodule

// File: doc/iob_rom_sp_reader.md
# iob_rom_sp_reader

Initiator-side companion to the single-port ROM: drives the ROM's `r_en`/`addr` and consumes its one-cycle-latency `r_data`. On a `start` command it fetches a contiguous block of words and delivers them on a valid/ready stream with full backpressure support. It sustains one word per cycle when the sink never stalls. It sits between a ROM instance and any streaming consumer, such as a boot loader, a table sequencer or a UART transmitter.

## Interface
- `DATA_W`, 8, ROM word width.
- `ADDR_W`, 10, ROM address width.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only while `busy`=0.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `len`  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with `start`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse when a command completes.
- `rom_r_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_r_data`  in  DATA_W  ROM data; valid the cycle after `rom_r_en`.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  sink ready.
- `m_data`  out  DATA_W  stream word.
- `m_last`  out  1  marks the final word of a pass.

## Operation
- FSM states are IDLE, RUN and FLUSH.
- **IDLE → RUN:** `start`=1 and `len`≠0. On this edge, latch `base_addr` into the address counter and `len` into the issue and delivery counters.
- **IDLE, `len`=0:** `start`=1 with `len`=0 pulses `done` on the next cycle. No ROM reads, no stream output, and `busy` stays 0.
- **Issue rule in RUN:** `rom_r_en`=1 iff the issue counter is >0 and (buffer occupancy + `rom_r_en` of the previous cycle − pop this cycle) < 2.
  - Pop means `m_valid`&`m_ready`.
  - Each issue increments the address counter and decrements the issue counter.
- **Address wrap:** addresses wrap modulo 2^ADDR_W (e.g. base 1022, len 4 reads 1022, 1023, 0, 1).
- **RUN → FLUSH:** the issue counter reaches 0.
- **FLUSH → IDLE:** the word with `m_last`=1 is popped. `done` pulses in the following cycle and `busy` drops on the same edge.
- **Output buffer:** 2-entry FIFO.
  - Write: the cycle after each `rom_r_en`, `rom_r_data` is written at the end of that cycle.
  - `m_data`/`m_valid` come from the head entry.
  - `m_last`=1 on the head entry iff it is the final word, tracked by the delivery counter.
  - A simultaneous write and pop is legal and keeps occupancy constant. The buffer never overflows.
- **Stream rules:** once `m_valid`=1, `m_valid` and `m_data` hold until popped.
- **`start` while busy:** ignored.
- **`rom_addr` when not reading:** holds its last value while `rom_r_en`=0.
- **Reset values (all outputs 0):** `busy`, `done`, `rom_r_en`, `rom_addr`, `m_valid`, `m_data`, `m_last`. FSM goes to IDLE, counters and buffer are cleared.
- **Reset mid-operation:** aborts the command with no `done`, and ROM data still in flight is discarded.

## Timing
- Command latency: `start` high in cycle 0 gives `busy`=1 and the first `rom_r_en` in cycle 1, then `m_valid`=1 in cycle 3.
- Throughput: with `m_ready` held at 1, one word per cycle. A len=N command completes with its last pop in cycle N+2 and `done` in cycle N+3.
- Stall: while `m_ready`=0 with 2 entries buffered, `rom_r_en`=0. Issue resumes in the same cycle as the first pop.
- Back-to-back: a new `start` is accepted in the `done` cycle, since `busy`=0 there.

## Configuration
- Macro: `IOB_ROM_SP_READER_LOOP_EN`.
- **Defined:**
  - Adds input `loop` (1 bit), sampled every cycle.
  - When the issue counter reaches 0 with `loop`=1, the address reloads with the latched base, the issue counter reloads with the latched length, and the FSM stays in RUN.
  - `m_last` marks the final word of every pass.
  - The command ends (FLUSH, `done`) only after a pass during whose final issue `loop`=0.
- **Undefined:** the port is absent and every command is a single pass.

## Test plan
- **Single pass:** reset, then ROM holding addr×3 (mod 2^DATA_W), base 5, len 4, `m_ready`=1.
  - `m_data` is 15, 18, 21, 24 in cycles 3–6, with `m_last` on 24.
  - `done` pulses in cycle 7.
- **Backpressure:** len 6 with `m_ready` toggling 1,0,0,1,…
  - Words arrive in order with none lost or duplicated.
  - `rom_r_en` never issues with 2 entries buffered and no pop.
- **Wrap:** base 1022, len 4 → `rom_addr` sequence 1022, 1023, 0, 1.
- **Zero length and ignored start:** len=0 → `done` in the next cycle with no `rom_r_en`. A `start` asserted mid-command is ignored.
- **Reset mid-command:** `rst` after 2 of 8 words → all outputs 0 the next cycle, no `done`. A fresh command then runs correctly.
- **Loop mode (macro defined):** len 3 with `loop`=1 for two passes → 9 words, `m_last` on words 3, 6 and 9, a single `done` at the end.
